// File: rtl/pc_unit.sv
// Program counter with jump, relative branch, call/return stack and stall.
// One action per cycle; all outputs come from registered state.
module pc_unit #(
    parameter int PC_W = 8,
    parameter int OFF_W = 6,
    parameter int RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             inc,
    input  logic             jump,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic [PC_W-1:0]  target,
    input  logic [OFF_W-1:0] branch_off,
    output logic [PC_W-1:0]  pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0]  stack [RAS_DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic             err_nxt;
    logic             push;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_br;
    logic [PC_W-1:0]  off_ext;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;

    assign pc_inc   = pc + PC_W'(1);
    assign off_ext  = {{(PC_W-OFF_W){branch_off[OFF_W-1]}}, branch_off};
    assign pc_br    = pc + off_ext;
    assign push_idx = IDX_W'(count);
    assign pop_idx  = IDX_W'(count - CNT_W'(1));

    assign ras_empty = (count == '0);
    assign ras_full  = (count == CNT_W'(RAS_DEPTH));

    always_comb begin
        pc_nxt    = pc;
        count_nxt = count;
        err_nxt   = ras_err;
        push      = 1'b0;
        if (stall) begin
            pc_nxt = pc;
        end else if (ret) begin
            if (ras_empty) begin
                err_nxt = 1'b1;
            end else begin
                pc_nxt    = stack[pop_idx];
                count_nxt = count - CNT_W'(1);
            end
        end else if (call) begin
            pc_nxt = target;
            if (ras_full) begin
                err_nxt = 1'b1;
            end else begin
                push      = 1'b1;
                count_nxt = count + CNT_W'(1);
            end
        end else if (jump) begin
            pc_nxt = target;
        end else if (branch) begin
            pc_nxt = pc_br;
        end else if (inc) begin
            pc_nxt = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_VEC;
            count   <= '0;
            ras_err <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            count   <= count_nxt;
            ras_err <= err_nxt;
        end
    end

    // Entries need no reset; count alone defines which are valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; expected outputs queue up as each step is
// driven and are checked one cycle later.
module tb_pc_unit;

    localparam logic [6:0] R = 7'b1000000;
    localparam logic [6:0] S = 7'b0100000;
    localparam logic [6:0] T = 7'b0010000;
    localparam logic [6:0] C = 7'b0001000;
    localparam logic [6:0] J = 7'b0000100;
    localparam logic [6:0] B = 7'b0000010;
    localparam logic [6:0] I = 7'b0000001;
    localparam logic [6:0] N = 7'b0000000;

    typedef struct {
        logic [7:0] pc;
        logic       e;
        logic       f;
        logic       r;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, stall, inc, jump, branch, call, ret;
    logic [7:0] target;
    logic [5:0] branch_off;
    logic [7:0] pc;
    logic       ras_empty, ras_full, ras_err;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    pc_unit #(
        .PC_W(8),
        .OFF_W(6),
        .RAS_DEPTH(4),
        .RESET_VEC(8'h10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .inc(inc),
        .jump(jump),
        .branch(branch),
        .call(call),
        .ret(ret),
        .target(target),
        .branch_off(branch_off),
        .pc(pc),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic step(input logic [6:0] ctl, input logic [7:0] tgt,
                        input logic [5:0] off, input logic [7:0] epc,
                        input logic ee, input logic ef, input logic er,
                        input string tag);
        exp_t x;
        {reset, stall, ret, call, jump, branch, inc} = ctl;
        target     = tgt;
        branch_off = off;
        sb.push_back('{pc: epc, e: ee, f: ef, r: er, tag: tag});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        checks++;
        assert (pc === x.pc) else begin
            errors++;
            $error("FAIL %s pc: got %h want %h", x.tag, pc, x.pc);
        end
        checks++;
        assert (ras_empty === x.e) else begin
            errors++;
            $error("FAIL %s ras_empty: got %b want %b", x.tag, ras_empty, x.e);
        end
        checks++;
        assert (ras_full === x.f) else begin
            errors++;
            $error("FAIL %s ras_full: got %b want %b", x.tag, ras_full, x.f);
        end
        checks++;
        assert (ras_err === x.r) else begin
            errors++;
            $error("FAIL %s ras_err: got %b want %b", x.tag, ras_err, x.r);
        end
    endtask

    initial begin
        {reset, stall, ret, call, jump, branch, inc} = R;
        target     = '0;
        branch_off = '0;
        @(posedge clk);
        #1;

        step(R, 8'h00, 6'h00, 8'h10, 1, 0, 0, "reset");
        step(I, 8'h00, 6'h00, 8'h11, 1, 0, 0, "inc1");
        step(I, 8'h00, 6'h00, 8'h12, 1, 0, 0, "inc2");
        step(I, 8'h00, 6'h00, 8'h13, 1, 0, 0, "inc3");
        step(J, 8'hFE, 6'h00, 8'hFE, 1, 0, 0, "jump_fe");
        step(I, 8'h00, 6'h00, 8'hFF, 1, 0, 0, "inc_ff");
        step(I, 8'h00, 6'h00, 8'h00, 1, 0, 0, "inc_wrap");
        step(N, 8'h00, 6'h00, 8'h00, 1, 0, 0, "hold");

        step(J, 8'h20, 6'h00, 8'h20, 1, 0, 0, "jump_20");
        step(B, 8'h00, 6'h3C, 8'h1C, 1, 0, 0, "br_neg");
        step(B, 8'h00, 6'h05, 8'h21, 1, 0, 0, "br_pos");
        step(J|B|I, 8'h80, 6'h05, 8'h80, 1, 0, 0, "prio_jump");
        step(J, 8'h02, 6'h00, 8'h02, 1, 0, 0, "jump_02");
        step(B, 8'h00, 6'h3C, 8'hFE, 1, 0, 0, "br_wrap_dn");
        step(B, 8'h00, 6'h1F, 8'h1D, 1, 0, 0, "br_wrap_up");

        step(J, 8'h05, 6'h00, 8'h05, 1, 0, 0, "jump_05");
        step(C, 8'h40, 6'h00, 8'h40, 0, 0, 0, "call_40");
        step(C|J|B, 8'h60, 6'h01, 8'h60, 0, 0, 0, "call_60");
        step(T|C|J, 8'h77, 6'h00, 8'h41, 0, 0, 0, "ret_41");
        step(T, 8'h00, 6'h00, 8'h06, 1, 0, 0, "ret_06");

        step(C, 8'hA0, 6'h00, 8'hA0, 0, 0, 0, "ovf_c1");
        step(C, 8'hB0, 6'h00, 8'hB0, 0, 0, 0, "ovf_c2");
        step(C, 8'hC0, 6'h00, 8'hC0, 0, 0, 0, "ovf_c3");
        step(C, 8'hD0, 6'h00, 8'hD0, 0, 1, 0, "ovf_c4");
        step(C, 8'hE0, 6'h00, 8'hE0, 0, 1, 1, "ovf_c5");
        step(T, 8'h00, 6'h00, 8'hC1, 0, 0, 1, "ovf_ret");
        for (int k = 0; k < 10; k++) begin
            step(N, 8'h00, 6'h00, 8'hC1, 0, 0, 1, "err_sticky");
        end
        step(R, 8'h00, 6'h00, 8'h10, 1, 0, 0, "reset2");
        step(T, 8'h00, 6'h00, 8'h10, 1, 0, 1, "underflow");

        step(R, 8'h00, 6'h00, 8'h10, 1, 0, 0, "reset3");
        step(J, 8'h32, 6'h00, 8'h32, 1, 0, 0, "jump_32");
        step(C, 8'h50, 6'h00, 8'h50, 0, 0, 0, "call_50");
        step(S|C|I, 8'h90, 6'h00, 8'h50, 0, 0, 0, "stall1");
        step(S|T|I, 8'h90, 6'h00, 8'h50, 0, 0, 0, "stall2");
        step(S|C|T|J, 8'h90, 6'h00, 8'h50, 0, 0, 0, "stall3");
        step(C|T, 8'h70, 6'h00, 8'h33, 1, 0, 0, "call_ret");
        step(T, 8'h00, 6'h00, 8'h33, 1, 0, 1, "no_push");

        step(R, 8'h00, 6'h00, 8'h10, 1, 0, 0, "reset4");
        step(C, 8'h40, 6'h00, 8'h40, 0, 0, 0, "mid_c1");
        step(C, 8'h50, 6'h00, 8'h50, 0, 0, 0, "mid_c2");
        step(R|T|S, 8'h00, 6'h00, 8'h10, 1, 0, 0, "mid_reset");
        step(T, 8'h00, 6'h00, 8'h10, 1, 0, 1, "post_ret");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
